fp_mul_round_pack: RTL
======================

# fp_mul_round_pack

Post-multiply stage of the single-precision floating-point multiplier. It consumes the 48-bit mantissa product produced by the 24×24 shift-add sequential multiplier datapath ({P register, A register}) together with operand signs and exponents. It normalizes, rounds to nearest-even and packs an IEEE-754 binary32 result, with flush-to-zero and saturate-to-infinity. It uses valid/ready handshakes on both sides so it can sit directly behind the multiplier controller's done pulse.

## Interface
- No parameters; widths fixed: product 48, exponent 8, result 32.
- Reset is rst, asynchronous, active-high; the clock is clk.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  product and operand fields valid
- in_ready  out  1  block idle, can accept (= state IDLE)
- in_prod  in  48  unsigned mantissa product {Preg, Areg}; hidden bits included, so normal operands give value in [2^46, 2^48)
- in_sign_a, in_sign_b  in  1 each  operand signs
- in_exp_a, in_exp_b  in  8 each  biased operand exponents
- in_zero  in  1  at least one operand is zero
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- result  out  32  packed {sign, exp[7:0], frac[22:0]}
- overflow  out  1  result saturated to ±Inf
- underflow  out  1  result flushed to ±0 due to exponent underflow

## Operation
- States: IDLE, NORM, ROUND, PACK, HOLD; one cycle each except IDLE and HOLD.
- IDLE: in_ready=1. On in_valid, capture the following, then go to NORM; otherwise stay in IDLE:
  - prod
  - zero flag
  - sign = sign_a ^ sign_b
  - e = exp_a + exp_b − 127, held as a 10-bit signed value (range −127..383; no wrap)
- NORM, if prod[47]=1:
  - mant = prod[47:24], guard = prod[23], sticky = |prod[22:0]
  - e = e+1
- NORM, else:
  - mant = prod[46:23], guard = prod[22], sticky = |prod[21:0]
- ROUND:
  - inc = guard & (sticky | mant[0])
  - 25-bit sum = mant + inc
  - On carry out: mant = sum[24:1] (=0x800000), e = e+1
- PACK, first matching rule wins:
  - zero → {sign, 31'b0}, flags 0
  - e ≥ 255 → {sign, 8'hFF, 23'b0}, overflow=1
  - e ≤ 0 → {sign, 31'b0}, underflow=1
  - else → {sign, e[7:0], mant[22:0]}
- PACK registers result and flags and moves to HOLD.
- HOLD: out_valid=1; result and flags stable. On out_ready go to IDLE and drop out_valid.
- Outside IDLE, in_valid is ignored. Outside HOLD, out_ready is ignored.
- No NaN/Inf/denormal inputs are supported; in_zero is the only special case.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, overflow=0, underflow=0, internal registers 0.
- Capture at edge k (in_valid & in_ready). Then:
  - NORM during k..k+1, ROUND k+1..k+2, PACK k+2..k+3
  - out_valid high after edge k+3 (latency 3 cycles)
- out_ready high when out_valid rises → accepted at edge k+4. in_ready is high again after that edge, so the next capture can occur at edge k+5 (throughput one result per 5 cycles).
- out_ready held low: HOLD persists indefinitely, outputs unchanged.
- rst asserted in any state: immediate return to reset values; an in-flight operation is discarded and no partial out_valid appears.
- Simultaneous in_valid and out_ready while in HOLD: accepts the result only; the new input is taken no earlier than the following IDLE cycle.

## Test plan
- Basic normalization: 1.5×1.5 with prod=0x900000000000, exps 127/127, signs 0/0 → result 0x40100000 three cycles after capture, flags 0. Then 1.0×1.0 with prod=0x400000000000 → 0x3F800000.
- Sign and exponent: exps 128/128, prod=0x600000000000, signs 1/0 → 0xC0C00000 (−6.0).
- Round-to-nearest-even, exps 127/127:
  - prod=0x400000400000 (tie, even) → 0x3F800000
  - prod=0x400000C00000 (tie, odd) → 0x3F800002
  - prod=0xFFFFFFFFFFFF (rounding carry) → 0x40800000
- Overflow, underflow and zero:
  - exps 254/254, prod=0x400000000000 → 0x7F800000, overflow=1
  - exps 1/1 → 0x00000000, underflow=1
  - in_zero=1, sign_a=1 → 0x80000000, flags 0
- Handshake: hold out_ready low 10 cycles; out_valid and result stay stable and in_valid pulses are ignored. Then out_ready=1 → accepted, in_ready=1 the next cycle.
- Reset mid-operation: assert rst during ROUND → out_valid=0, in_ready=1 immediately. After release, a fresh 1.0×1.0 returns 0x3F800000.

Source files
------------

// File: rtl/fp_mul_round_pack.sv
// Post-multiply normalize / round-to-nearest-even / pack stage for binary32 multiply.
// Takes the 48-bit mantissa product and operand fields, and produces a packed result with saturate and flush flags.
`timescale 1ns/1ps

module fp_mul_round_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_prod,
    input  logic        in_sign_a,
    input  logic        in_sign_b,
    input  logic [7:0]  in_exp_a,
    input  logic [7:0]  in_exp_b,
    input  logic        in_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, HOLD} state_t;

    state_t state, state_next;

    logic [47:0]        prod_q;
    logic               zero_q;
    logic               sign_q;
    logic signed [9:0]  e_q;
    logic [23:0]        mant_q;
    logic               guard_q;
    logic               sticky_q;

    logic signed [9:0]  exp_sum;
    logic               round_inc;
    logic [24:0]        round_sum;

    // Ten bits hold the full -127..383 range; the unsigned sum wraps to the correct two's-complement value.
    assign exp_sum   = {2'b00, in_exp_a} + {2'b00, in_exp_b} - 10'd127;
    assign round_inc = guard_q & (sticky_q | mant_q[0]);
    assign round_sum = {1'b0, mant_q} + {24'd0, round_inc};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = PACK;
            PACK:    state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q    <= '0;
            zero_q    <= 1'b0;
            sign_q    <= 1'b0;
            e_q       <= '0;
            mant_q    <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        prod_q <= in_prod;
                        zero_q <= in_zero;
                        sign_q <= in_sign_a ^ in_sign_b;
                        e_q    <= exp_sum;
                    end
                end
                NORM: begin
                    if (prod_q[47]) begin
                        mant_q   <= prod_q[47:24];
                        guard_q  <= prod_q[23];
                        sticky_q <= |prod_q[22:0];
                        e_q      <= e_q + 10'sd1;
                    end else begin
                        mant_q   <= prod_q[46:23];
                        guard_q  <= prod_q[22];
                        sticky_q <= |prod_q[21:0];
                    end
                end
                ROUND: begin
                    // A carry out of the rounder can only come from all-ones, leaving 1.0 and a bumped exponent.
                    if (round_sum[24]) begin
                        mant_q <= round_sum[24:1];
                        e_q    <= e_q + 10'sd1;
                    end else begin
                        mant_q <= round_sum[23:0];
                    end
                end
                PACK: begin
                    if (zero_q) begin
                        result    <= {sign_q, 31'b0};
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end else if (e_q >= 10'sd255) begin
                        result    <= {sign_q, 8'hFF, 23'b0};
                        overflow  <= 1'b1;
                        underflow <= 1'b0;
                    end else if (e_q <= 10'sd0) begin
                        result    <= {sign_q, 31'b0};
                        overflow  <= 1'b0;
                        underflow <= 1'b1;
                    end else begin
                        result    <= {sign_q, e_q[7:0], mant_q[22:0]};
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
